fetch_queue: RTL and testbench

- Downstream consumer of the byte-to-word memory assembler.
- Accepts each completed 32-bit word, which arrives big-endian assembled with a one-cycle done pulse.
- Byte-swaps the word into little-endian RISC-V instruction order, tags it with its PC and buffers it in a small FIFO.
- Presents instructions to decode with a valid/ready handshake. Throttles the assembler and restarts it on a branch redirect.

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue_sync_fifo.sv | 46 ++++
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entries pair each little-endian instruction with the PC it was fetched from.
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } inst_entry_t;

  // The assembler delivers the first byte in the top lane; RISC-V wants it lowest.
  function automatic logic [XLEN-1:0] byte_swap(input logic [XLEN-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Assembler-side, execute-side and decode-side signals of the fetch queue.
// The slave modport is the queue itself; master is whoever drives it.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic [XLEN-1:0] wd_i;
  logic            wd_ok_i;
  logic            fetch_en_o;
  logic            restart_o;
  logic [XLEN-1:0] restart_addr_o;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] pc_o;
  logic            valid_o;
  logic            ready_i;
  logic            overflow_o;

  modport master (
    output wd_i, wd_ok_i, redirect_i, redirect_pc_i, ready_i,
    input  fetch_en_o, restart_o, restart_addr_o, inst_o, pc_o, valid_o, overflow_o
  );

  modport slave (
    input  wd_i, wd_ok_i, redirect_i, redirect_pc_i, ready_i,
    output fetch_en_o, restart_o, restart_addr_o, inst_o, pc_o, valid_o, overflow_o
  );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Generic single-clock FIFO with flush and occupancy count; read data is the
// combinational head entry. The caller never writes when full without also reading.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush && !rst) mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
endmodule

// File: rtl/fetch_queue.sv
// Buffers assembled words as PC-tagged little-endian instructions for decode,
// throttles the assembler, and restarts it after a branch redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   count;
  inst_entry_t     head;
  inst_entry_t     enq_entry;
  logic [XLEN-1:0] enq_pc_reg;
  logic            restart_reg;
  logic [XLEN-1:0] restart_addr_reg;
  logic            overflow_reg;
  logic            valid;
  logic            full;
  logic            word_live;
  logic            deq;
  logic            enq;
  logic            ovf;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign deq   = valid & bus.ready_i & ~bus.redirect_i;
  // A word arriving in the redirect or restart cycle belongs to the old stream.
  assign word_live = bus.wd_ok_i & ~bus.redirect_i & ~restart_reg;
  assign enq   = word_live & (~full | deq);
  assign ovf   = word_live & full & ~deq;

  assign enq_entry.pc   = enq_pc_reg;
  assign enq_entry.inst = byte_swap(bus.wd_i);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(inst_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.redirect_i),
    .wr_en   (enq),
    .wr_data (enq_entry),
    .rd_en   (deq),
    .rd_data (head),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enq_pc_reg       <= RESET_PC;
      restart_reg      <= 1'b0;
      restart_addr_reg <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      restart_reg <= bus.redirect_i;
      if (bus.redirect_i) begin
        enq_pc_reg       <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
        restart_addr_reg <= {bus.redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (enq) begin
        enq_pc_reg <= enq_pc_reg + 32'd4;
      end
      if (ovf) overflow_reg <= 1'b1;
    end
  end

  // One slot stays free for the word the assembler may already be building.
  assign bus.fetch_en_o     = (count + 1'b1) < CW'(DEPTH);
  assign bus.restart_o      = restart_reg;
  assign bus.restart_addr_o = restart_addr_reg;
  assign bus.inst_o         = head.inst;
  assign bus.pc_o           = head.pc;
  assign bus.valid_o        = valid;
  assign bus.overflow_o     = overflow_reg;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, backpressure, full bypass,
// redirect, stale-word drop, back-to-back redirects and PC wrap.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] words [6];
  logic [31:0] swapped [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [31:0] w);
    bus.wd_i    = w;
    bus.wd_ok_i = 1'b1;
    tick();
    bus.wd_ok_i = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic do_reset();
    bus.wd_i          = '0;
    bus.wd_ok_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.ready_i       = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset_valid", 32'(bus.valid_o), 32'd0);
    chk("reset_fetch_en", 32'(bus.fetch_en_o), 32'd1);
    chk("reset_overflow", 32'(bus.overflow_o), 32'd0);
    chk("reset_restart", 32'(bus.restart_o), 32'd0);
    chk("reset_restart_addr", bus.restart_addr_o, 32'd0);
  endtask

  task automatic test_fill_drain();
    logic [31:0] w_in  [3];
    logic [31:0] i_exp [3];
    w_in[0] = 32'h1300_0000; i_exp[0] = 32'h0000_0013;
    w_in[1] = 32'h9300_0000; i_exp[1] = 32'h0000_0093;
    w_in[2] = 32'h1301_0000; i_exp[2] = 32'h0000_0113;
    do_reset();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse(w_in[i]);
      chk($sformatf("fd_valid%0d", i), 32'(bus.valid_o), 32'd1);
      chk($sformatf("fd_inst%0d", i), bus.inst_o, i_exp[i]);
      chk($sformatf("fd_pc%0d", i), bus.pc_o, 32'(i * 4));
      tick();
      chk($sformatf("fd_empty%0d", i), 32'(bus.valid_o), 32'd0);
      tick();
      tick();
    end
    chk("fd_overflow", 32'(bus.overflow_o), 32'd0);
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] pc_exp [4];
    int          idx_exp [4];
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.fetch_en_o) break;
      pulse(words[n]);
      n++;
    end
    chk("bp_words_before_throttle", 32'(n), 32'd3);
    chk("bp_fetch_en", 32'(bus.fetch_en_o), 32'd0);
    pulse(words[3]);
    chk("bp_fourth_overflow", 32'(bus.overflow_o), 32'd0);
    chk("bp_fourth_valid", 32'(bus.valid_o), 32'd1);
    // Full: dequeue and enqueue in the same cycle.
    bus.ready_i = 1'b1;
    pulse(words[4]);
    bus.ready_i = 1'b0;
    chk("full_bypass_overflow", 32'(bus.overflow_o), 32'd0);
    chk("full_bypass_fetch_en", 32'(bus.fetch_en_o), 32'd0);
    chk("full_bypass_head_pc", bus.pc_o, 32'h4);
    // Still full: this word must be dropped and flagged.
    pulse(words[5]);
    chk("bp_fifth_overflow", 32'(bus.overflow_o), 32'd1);
    pc_exp[0] = 32'h4;  idx_exp[0] = 1;
    pc_exp[1] = 32'h8;  idx_exp[1] = 2;
    pc_exp[2] = 32'hC;  idx_exp[2] = 3;
    pc_exp[3] = 32'h10; idx_exp[3] = 4;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_valid%0d", i), 32'(bus.valid_o), 32'd1);
      chk($sformatf("drain_inst%0d", i), bus.inst_o, swapped[idx_exp[i]]);
      chk($sformatf("drain_pc%0d", i), bus.pc_o, pc_exp[i]);
      tick();
    end
    chk("drain_empty", 32'(bus.valid_o), 32'd0);
    chk("overflow_sticky", 32'(bus.overflow_o), 32'd1);
    do_reset();
    chk("overflow_cleared_by_rst", 32'(bus.overflow_o), 32'd0);
  endtask

  task automatic test_redirect();
    do_reset();
    pulse(words[0]);
    pulse(words[1]);
    pulse(words[2]);
    chk("rd_prequeued_valid", 32'(bus.valid_o), 32'd1);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0106;
    bus.wd_i          = words[3];
    bus.wd_ok_i       = 1'b1;
    tick();
    bus.redirect_i = 1'b0;
    // Word offered during the restart pulse is from the old stream.
    bus.wd_i = words[4];
    chk("rd_valid_cleared", 32'(bus.valid_o), 32'd0);
    chk("rd_restart", 32'(bus.restart_o), 32'd1);
    chk("rd_restart_addr", bus.restart_addr_o, 32'h104);
    tick();
    bus.wd_ok_i = 1'b0;
    chk("rd_restart_one_cycle", 32'(bus.restart_o), 32'd0);
    chk("stale_dropped", 32'(bus.valid_o), 32'd0);
    chk("stale_fetch_en", 32'(bus.fetch_en_o), 32'd1);
    pulse(words[5]);
    chk("rd_new_valid", 32'(bus.valid_o), 32'd1);
    chk("rd_new_pc", bus.pc_o, 32'h104);
    chk("rd_new_inst", bus.inst_o, swapped[5]);
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    tick();
    chk("b2b_restart_a", 32'(bus.restart_o), 32'd1);
    chk("b2b_addr_a", bus.restart_addr_o, 32'h200);
    bus.redirect_pc_i = 32'h0000_0303;
    tick();
    bus.redirect_i = 1'b0;
    chk("b2b_restart_b", 32'(bus.restart_o), 32'd1);
    chk("b2b_addr_b", bus.restart_addr_o, 32'h300);
    tick();
    chk("b2b_restart_end", 32'(bus.restart_o), 32'd0);
    pulse(words[0]);
    chk("b2b_pc", bus.pc_o, 32'h300);
  endtask

  task automatic test_pc_wrap();
    do_reset();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    tick();
    pulse(words[1]);
    pulse(words[2]);
    chk("wrap_pc_first", bus.pc_o, 32'hFFFF_FFFC);
    chk("wrap_inst_first", bus.inst_o, swapped[1]);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk("wrap_pc_second", bus.pc_o, 32'h0000_0000);
    chk("wrap_inst_second", bus.inst_o, swapped[2]);
  endtask

  initial begin
    words[0] = 32'h1234_5678; swapped[0] = 32'h7856_3412;
    words[1] = 32'hAABB_CCDD; swapped[1] = 32'hDDCC_BBAA;
    words[2] = 32'h0102_0304; swapped[2] = 32'h0403_0201;
    words[3] = 32'hDEAD_BEEF; swapped[3] = 32'hEFBE_ADDE;
    words[4] = 32'hCAFE_F00D; swapped[4] = 32'h0DF0_FECA;
    words[5] = 32'h1122_3344; swapped[5] = 32'h4433_2211;
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_pc_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
